// File: rtl/lop_pipe.sv
// Multi-lane bitwise logic unit feeding a DEPTH-stage valid/ready pipeline.
// Global stall, synchronous flush and a wrapping completed-transfer counter.
module lop_pipe #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 2,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic [1:0]                op,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_a,
  input  logic [CHANNELS*WIDTH-1:0] in_b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_q,
  output logic [CNT_W-1:0]          out_count
);

  localparam int W = CHANNELS * WIDTH;

  logic [DEPTH-1:0] vld;
  logic [W-1:0]     dat [DEPTH];
  logic [W-1:0]     res;
  logic             accept;
  logic             xfer;

  // Pure bitwise ops: lanes never interact, so one wide op covers all.
  always_comb begin
    res = '0;
    unique case (op)
      2'b00: res = in_a & in_b;
      2'b01: res = in_a ^ in_b;
      2'b10: res = in_a | in_b;
      2'b11: res = ~(in_a ^ in_b);
    endcase
  end

  assign out_valid = vld[DEPTH-1];
  assign out_q     = dat[DEPTH-1];
  assign in_ready  = ~out_valid | out_ready;
  assign accept    = in_valid & in_ready;
  assign xfer      = out_valid & out_ready;

  // Data only moves with a valid beat, so out_q keeps its last result
  // when a bubble shifts into the final stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int i = 0; i < DEPTH; i++) dat[i] <= '0;
    end else if (flush) begin
      vld <= '0;
    end else if (in_ready) begin
      vld[0] <= accept;
      if (accept) dat[0] <= res;
      for (int i = 1; i < DEPTH; i++) begin
        vld[i] <= vld[i-1];
        if (vld[i-1]) dat[i] <= dat[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    out_count <= '0;
    else if (xfer) out_count <= out_count + 1'b1;
  end

endmodule

// File: tb/tb_lop_pipe.sv
// Directed bench for lop_pipe: main DEPTH=2 instance plus a
// DEPTH=1, CNT_W=4 instance for counter wrap.
module tb_lop_pipe;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        flush = 0;
  logic [1:0]  op = 0;
  logic        in_valid = 0;
  logic        in_ready;
  logic [15:0] in_a = 0;
  logic [15:0] in_b = 0;
  logic        out_valid;
  logic        out_ready = 1;
  logic [15:0] out_q;
  logic [15:0] out_count;

  logic        in_valid2 = 0;
  logic        in_ready2;
  logic        out_valid2;
  logic        out_ready2 = 0;
  logic [15:0] out_q2;
  logic [3:0]  out_count2;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] beats [4];

  always #5 clk = ~clk;

  lop_pipe #(.WIDTH(8), .CHANNELS(2), .DEPTH(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .op(op),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_q(out_q), .out_count(out_count)
  );

  lop_pipe #(.WIDTH(8), .CHANNELS(2), .DEPTH(1), .CNT_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .op(op),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .out_q(out_q2), .out_count(out_count2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset
    tick(); tick();
    rst_n = 1;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_count", out_count, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_q", out_q, 0);

    // basic AND
    in_a = 16'hF03C; in_b = 16'hAA0F; op = 2'b00; in_valid = 1;
    tick();
    in_valid = 0;
    chk("and_lat1", out_valid, 0);
    tick();
    chk("and_valid", out_valid, 1);
    chk("and_q", out_q, 16'hA00C);
    tick();
    chk("and_cnt", out_count, 1);
    chk("and_drain", out_valid, 0);

    // op sweep back-to-back
    in_valid = 1; op = 2'b01; tick();
    op = 2'b10; tick();
    chk("xor_q", out_q, 16'h5A33);
    op = 2'b11; tick();
    in_valid = 0;
    chk("or_q", out_q, 16'hFA3F);
    tick();
    chk("xnor_q", out_q, 16'hA5CC);
    chk("xnor_v", out_valid, 1);
    tick();
    chk("sweep_cnt", out_count, 4);

    // backpressure: beats pass through XOR with zero
    for (int i = 0; i < 4; i++)
      beats[i] = {8'h10 + 8'(i), 8'h20 + 8'(i)};
    out_ready = 0; op = 2'b01; in_b = 0; in_valid = 1;
    in_a = beats[0]; tick();
    in_a = beats[1]; tick();
    in_a = beats[2];
    chk("bp_ready0", in_ready, 0);
    chk("bp_q0", out_q, beats[0]);
    tick(); tick(); tick();
    chk("bp_hold_q", out_q, beats[0]);
    chk("bp_hold_v", out_valid, 1);
    chk("bp_cnt_hold", out_count, 4);
    out_ready = 1;
    #1;
    chk("bp_ready1", in_ready, 1);
    tick();
    chk("bp_q1", out_q, beats[1]);
    in_a = beats[3]; tick();
    chk("bp_q2", out_q, beats[2]);
    in_valid = 0; tick();
    chk("bp_q3", out_q, beats[3]);
    tick();
    chk("bp_empty", out_valid, 0);
    chk("bp_cnt", out_count, 8);

    // flush with two beats in flight
    in_valid = 1; in_a = 16'h1111; tick();
    in_a = 16'h2222; flush = 1; tick();
    flush = 0; in_valid = 0;
    chk("fl_valid0", out_valid, 0);
    tick(); tick();
    chk("fl_valid1", out_valid, 0);
    chk("fl_cnt", out_count, 8);
    chk("fl_q_hold", out_q, beats[3]);
    in_valid = 1; in_a = 16'h3C3C; tick();
    in_valid = 0; tick();
    chk("fl_new_v", out_valid, 1);
    chk("fl_new_q", out_q, 16'h3C3C);
    tick();
    chk("fl_new_cnt", out_count, 9);

    // async reset during a stall
    out_ready = 0; in_valid = 1; in_a = 16'h5555; tick();
    in_valid = 0; tick();
    chk("ar_stall_v", out_valid, 1);
    #2 rst_n = 0;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_q", out_q, 0);
    chk("ar_cnt", out_count, 0);
    chk("ar_ready", in_ready, 1);
    tick();
    rst_n = 1; out_ready = 1;
    in_valid = 1; op = 2'b10; in_a = 16'h0F00; in_b = 16'h00F0;
    tick();
    in_valid = 0; tick();
    chk("ar_resume_q", out_q, 16'h0FF0);
    tick();
    chk("ar_resume_cnt", out_count, 1);

    // counter wrap on the DEPTH=1, CNT_W=4 instance
    in_valid2 = 1; out_ready2 = 1;
    tick();
    chk("w_first_v", out_valid2, 1);
    chk("w_first_q", out_q2, 16'h0FF0);
    for (int k = 1; k <= 17; k++) begin
      tick();
      if (k == 15) chk("wrap15", out_count2, 15);
      if (k == 16) chk("wrap16", out_count2, 0);
      if (k == 17) chk("wrap17", out_count2, 1);
    end
    in_valid2 = 0;

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
